// File: rtl/hazard_pkg.sv
// Shared types and helpers for the pipeline hazard-control block.
// Holds the scoreboard entry layout, the x0 constant and the fwd_sel width helper.
package hazard_pkg;

    // Width of the rd field stored in each scoreboard entry.
    // The unit's REG_AW must not exceed it; narrower addresses are zero-extended.
    localparam int SB_RD_W = 5;

    localparam logic [SB_RD_W-1:0] REG_X0 = '0;

    typedef struct packed {
        logic               valid;
        logic [SB_RD_W-1:0] rd;
        logic               is_load;
    } sb_entry_t;

    // Width of a forwarding select over DEPTH stages.
    // Value 0 means regfile, so DEPTH+1 codes are needed.
    function automatic int fwd_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/hazard_match.sv
// Youngest-match priority search of the scoreboard for one source operand.
// Ports: sb (scoreboard), addr/used (operand), sel (forward select), load_hit.
module hazard_match
    import hazard_pkg::*;
#(
    parameter int DEPTH      = 3,
    parameter int LOAD_READY = 1,
    parameter int SEL_W      = 2
) (
    input  sb_entry_t [DEPTH-1:0] sb,
    input  logic [SB_RD_W-1:0]    addr,
    input  logic                  used,
    output logic [SEL_W-1:0]      sel,
    output logic                  load_hit
);

    logic [DEPTH-1:0] hit;

    always_comb begin
        hit = '0;
        for (int j = 0; j < DEPTH; j++) begin
            hit[j] = used
                   & (addr != REG_X0)
                   & sb[j].valid
                   & (sb[j].rd == addr);
        end
    end

    // Scan oldest to youngest so the lowest index
    // (youngest producer) is the last one written.
    always_comb begin
        sel = '0;
        for (int j = DEPTH - 1; j >= 0; j--) begin
            if (hit[j]) begin
                sel = SEL_W'(j + 1);
            end
        end
    end

    // A load whose data is not yet on any stage output
    // cannot be forwarded and must hold decode.
    always_comb begin
        load_hit = 1'b0;
        for (int j = 0; j < DEPTH; j++) begin
            if ((j < LOAD_READY) && hit[j] && sb[j].is_load) begin
                load_hit = 1'b1;
            end
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// Hazard control: scoreboard of in-flight rd behind decode, forwarding selects,
// load-use stall and branch/jump flush. Optional perf counters: HAZARD_PERF_EN.
// Ports: clk, rst_n; dec_* (decode instruction), exec_pc_src (redirect);
// stall_fetch/stall_decode, flush_decode/flush_exec, fwd_sel_rs1/rs2;
// stall_count/flush_count only when HAZARD_PERF_EN is defined.
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int DEPTH      = 3,
    parameter int REG_AW     = 5,
    parameter int LOAD_READY = 1,
    parameter int CNT_W      = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       dec_valid,
    input  logic [REG_AW-1:0]          dec_rs1_addr,
    input  logic [REG_AW-1:0]          dec_rs2_addr,
    input  logic                       dec_rs1_used,
    input  logic                       dec_rs2_used,
    input  logic [REG_AW-1:0]          dec_rd_addr,
    input  logic                       dec_rd_write_enable,
    input  logic                       dec_is_load,
    input  logic                       exec_pc_src,
    output logic                       stall_fetch,
    output logic                       stall_decode,
    output logic                       flush_decode,
    output logic                       flush_exec,
    output logic [fwd_w(DEPTH)-1:0]    fwd_sel_rs1,
    output logic [fwd_w(DEPTH)-1:0]    fwd_sel_rs2
`ifdef HAZARD_PERF_EN
    ,
    output logic [CNT_W-1:0]           stall_count,
    output logic [CNT_W-1:0]           flush_count
`endif
);

    localparam int SEL_W = fwd_w(DEPTH);

    if (LOAD_READY >= DEPTH || DEPTH < 2
        || REG_AW > SB_RD_W || REG_AW < 1 || CNT_W < 1) begin : g_param_check
        $error("hazard_unit: need DEPTH>=2, LOAD_READY<DEPTH, REG_AW<=%0d",
               SB_RD_W);
    end

    sb_entry_t [DEPTH-1:0] sb_q;
    sb_entry_t             sb_in;

    logic [SB_RD_W-1:0] rs1_ext;
    logic [SB_RD_W-1:0] rs2_ext;
    logic [SB_RD_W-1:0] rd_ext;

    logic [SEL_W-1:0] sel_rs1;
    logic [SEL_W-1:0] sel_rs2;
    logic             lu_rs1;
    logic             lu_rs2;
    logic             stall;
    logic             flush;

    assign rs1_ext = SB_RD_W'(dec_rs1_addr);
    assign rs2_ext = SB_RD_W'(dec_rs2_addr);
    assign rd_ext  = SB_RD_W'(dec_rd_addr);

    hazard_match #(
        .DEPTH      (DEPTH),
        .LOAD_READY (LOAD_READY),
        .SEL_W      (SEL_W)
    ) u_match_rs1 (
        .sb       (sb_q),
        .addr     (rs1_ext),
        .used     (dec_rs1_used),
        .sel      (sel_rs1),
        .load_hit (lu_rs1)
    );

    hazard_match #(
        .DEPTH      (DEPTH),
        .LOAD_READY (LOAD_READY),
        .SEL_W      (SEL_W)
    ) u_match_rs2 (
        .sb       (sb_q),
        .addr     (rs2_ext),
        .used     (dec_rs2_used),
        .sel      (sel_rs2),
        .load_hit (lu_rs2)
    );

    // Outputs are held low while reset is asserted; a redirect
    // wins over a load-use stall since the stalled op is squashed.
    always_comb begin
        flush = rst_n & exec_pc_src;
        stall = rst_n & dec_valid & ~exec_pc_src & (lu_rs1 | lu_rs2);
    end

    always_comb begin
        stall_fetch  = stall;
        stall_decode = stall;
        flush_decode = flush;
        flush_exec   = flush;
        fwd_sel_rs1  = sel_rs1;
        fwd_sel_rs2  = sel_rs2;
    end

    // Entry entering exec; a stall or flush turns it into a bubble.
    always_comb begin
        sb_in         = '0;
        sb_in.valid   = dec_valid
                      & dec_rd_write_enable
                      & (rd_ext != REG_X0);
        sb_in.rd      = rd_ext;
        sb_in.is_load = dec_is_load;
        if (stall || exec_pc_src) begin
            sb_in = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb_q <= '0;
        end else begin
            sb_q <= {sb_q[DEPTH-2:0], sb_in};
        end
    end

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (stall) begin
                stall_count <= stall_count + CNT_W'(1);
            end
            if (flush) begin
                flush_count <= flush_count + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit with an issue-history reference model.
// Checks every cycle against the model plus hand-computed literal values.
module tb_hazard_unit;

    localparam int DEPTH      = 3;
    localparam int LOAD_READY = 1;
    localparam int CNT_W      = 32;
    localparam int HN         = 1024;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       dec_valid = 1'b0;
    logic [4:0] dec_rs1_addr = '0;
    logic [4:0] dec_rs2_addr = '0;
    logic       dec_rs1_used = 1'b0;
    logic       dec_rs2_used = 1'b0;
    logic [4:0] dec_rd_addr = '0;
    logic       dec_rd_write_enable = 1'b0;
    logic       dec_is_load = 1'b0;
    logic       exec_pc_src = 1'b0;
    logic       stall_fetch;
    logic       stall_decode;
    logic       flush_decode;
    logic       flush_exec;
    logic [1:0] fwd_sel_rs1;
    logic [1:0] fwd_sel_rs2;
`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;
`endif

    hazard_unit #(
        .DEPTH      (DEPTH),
        .REG_AW     (5),
        .LOAD_READY (LOAD_READY),
        .CNT_W      (CNT_W)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .dec_valid           (dec_valid),
        .dec_rs1_addr        (dec_rs1_addr),
        .dec_rs2_addr        (dec_rs2_addr),
        .dec_rs1_used        (dec_rs1_used),
        .dec_rs2_used        (dec_rs2_used),
        .dec_rd_addr         (dec_rd_addr),
        .dec_rd_write_enable (dec_rd_write_enable),
        .dec_is_load         (dec_is_load),
        .exec_pc_src         (exec_pc_src),
        .stall_fetch         (stall_fetch),
        .stall_decode        (stall_decode),
        .flush_decode        (flush_decode),
        .flush_exec          (flush_exec),
        .fwd_sel_rs1         (fwd_sel_rs1),
        .fwd_sel_rs2         (fwd_sel_rs2)
`ifdef HAZARD_PERF_EN
        ,
        .stall_count         (stall_count),
        .flush_count         (flush_count)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a log of what left decode each cycle.
    // The instruction issued k cycles ago now sits in stage k-1.
    // A bubble or a write to x0 is logged as rd 0, which never matches.
    int         cyc   = 0;
    int         start = 0;
    logic [4:0] hrd [HN];
    logic       hld [HN];
    int         m_stalls = 0;
    int         m_flushes = 0;

    function automatic bit producer(int k, logic [4:0] r, logic u);
        int idx;
        idx = cyc - k;
        if (idx < start || !u || r == 5'd0) return 1'b0;
        return hrd[idx % HN] == r;
    endfunction

    function automatic int exp_sel(logic [4:0] r, logic u);
        for (int k = 1; k <= DEPTH; k++) begin
            if (producer(k, r, u)) return k;
        end
        return 0;
    endfunction

    function automatic bit load_use(logic [4:0] r, logic u);
        for (int k = 1; k <= LOAD_READY; k++) begin
            if (producer(k, r, u) && hld[(cyc - k) % HN]) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic bit exp_stall();
        return rst_n && dec_valid && !exec_pc_src
            && (load_use(dec_rs1_addr, dec_rs1_used)
             || load_use(dec_rs2_addr, dec_rs2_used));
    endfunction

    function automatic bit exp_flush();
        return rst_n && exec_pc_src;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start     <= cyc;
            m_stalls  <= 0;
            m_flushes <= 0;
        end else begin
            hrd[cyc % HN] <= (dec_valid && dec_rd_write_enable
                              && !exp_stall() && !exec_pc_src)
                             ? dec_rd_addr : 5'd0;
            hld[cyc % HN] <= dec_is_load;
            cyc <= cyc + 1;
            if (exp_stall()) m_stalls <= m_stalls + 1;
            if (exp_flush()) m_flushes <= m_flushes + 1;
        end
    end

    always @(negedge clk) begin
        check("stall_fetch", stall_fetch, exp_stall());
        check("stall_decode", stall_decode, exp_stall());
        check("flush_decode", flush_decode, exp_flush());
        check("flush_exec", flush_exec, exp_flush());
        if (!exp_stall()) begin
            check("fwd_sel_rs1", fwd_sel_rs1, exp_sel(dec_rs1_addr, dec_rs1_used));
            check("fwd_sel_rs2", fwd_sel_rs2, exp_sel(dec_rs2_addr, dec_rs2_used));
        end
`ifdef HAZARD_PERF_EN
        check("stall_count", stall_count, m_stalls);
        check("flush_count", flush_count, m_flushes);
`endif
    end

    task automatic set_in(input logic v, input logic [4:0] rd, input logic we,
                          input logic ld, input logic [4:0] r1, input logic u1,
                          input logic [4:0] r2, input logic u2, input logic pc);
        dec_valid           = v;
        dec_rd_addr         = rd;
        dec_rd_write_enable = we;
        dec_is_load         = ld;
        dec_rs1_addr        = r1;
        dec_rs1_used        = u1;
        dec_rs2_addr        = r2;
        dec_rs2_used        = u2;
        exec_pc_src         = pc;
    endtask

    task automatic drv(input logic v, input logic [4:0] rd, input logic we,
                       input logic ld, input logic [4:0] r1, input logic u1,
                       input logic [4:0] r2, input logic u2, input logic pc);
        @(posedge clk);
        #1;
        set_in(v, rd, we, ld, r1, u1, r2, u2, pc);
        #2;
    endtask

    task automatic nop();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        #12;
        check("rst_stall", stall_decode, 0);
        check("rst_flush", flush_exec, 0);
        check("rst_fwd1", fwd_sel_rs1, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // ADD x5 ; ADD x6,x5,x5
        drv(1, 5, 1, 0, 1, 1, 2, 1, 0);
        check("add_first_fwd1", fwd_sel_rs1, 0);
        drv(1, 6, 1, 0, 5, 1, 5, 1, 0);
        check("raw_fwd1", fwd_sel_rs1, 1);
        check("raw_fwd2", fwd_sel_rs2, 1);
        check("raw_stall", stall_decode, 0);

        // LW x7 ; ADD x8,x7,x1 stalls once, then forwards from memacc
        drv(1, 7, 1, 1, 0, 1, 0, 0, 0);
        drv(1, 8, 1, 0, 7, 1, 1, 1, 0);
        check("lu_stall_dec", stall_decode, 1);
        check("lu_stall_fetch", stall_fetch, 1);
        check("lu_flush", flush_exec, 0);
        drv(1, 8, 1, 0, 7, 1, 1, 1, 0);
        check("lu_after_stall", stall_decode, 0);
        check("lu_after_fwd1", fwd_sel_rs1, 2);
        check("lu_after_fwd2", fwd_sel_rs2, 0);

        // ADDI x0,x0,1 ; consumer of x0
        drv(1, 0, 1, 0, 0, 1, 0, 0, 0);
        drv(1, 3, 1, 0, 0, 1, 0, 1, 0);
        check("x0_fwd1", fwd_sel_rs1, 0);
        check("x0_fwd2", fwd_sel_rs2, 0);
        check("x0_stall", stall_decode, 0);

        // x9 reaches writeback
        drv(1, 9, 1, 0, 0, 0, 0, 0, 0);
        nop();
        nop();
        drv(1, 4, 1, 0, 9, 1, 2, 0, 0);
        check("wb_fwd1", fwd_sel_rs1, 3);

        // x9 in sb[0] and sb[2]: youngest wins
        drv(1, 9, 1, 0, 0, 0, 0, 0, 0);
        nop();
        drv(1, 9, 1, 0, 0, 0, 0, 0, 0);
        drv(1, 4, 1, 0, 9, 1, 9, 1, 0);
        check("young_fwd1", fwd_sel_rs1, 1);
        check("young_fwd2", fwd_sel_rs2, 1);

        // Redirect during a pending load-use stall
        drv(1, 10, 1, 1, 0, 1, 0, 0, 0);
        drv(1, 11, 1, 0, 10, 1, 0, 0, 1);
        check("fl_flush_dec", flush_decode, 1);
        check("fl_flush_exec", flush_exec, 1);
        check("fl_stall_dec", stall_decode, 0);
        check("fl_stall_fetch", stall_fetch, 0);
        drv(1, 12, 1, 0, 10, 1, 11, 1, 0);
        check("fl_bubble_fwd1", fwd_sel_rs1, 2);
        check("fl_bubble_fwd2", fwd_sel_rs2, 0);
        check("fl_bubble_stall", stall_decode, 0);

        // Reset with three valid entries in flight
        drv(1, 13, 1, 0, 0, 0, 0, 0, 0);
        drv(1, 14, 1, 0, 0, 0, 0, 0, 0);
        drv(1, 15, 1, 1, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        set_in(1, 16, 1, 0, 15, 1, 14, 1, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_fwd1", fwd_sel_rs1, 0);
        check("mid_rst_fwd2", fwd_sel_rs2, 0);
        check("mid_rst_flush", flush_decode, 0);
        check("mid_rst_stall", stall_decode, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        set_in(1, 16, 1, 0, 15, 1, 14, 1, 0);
        #2;
        check("post_rst_fwd1", fwd_sel_rs1, 0);
        check("post_rst_fwd2", fwd_sel_rs2, 0);
        check("post_rst_stall", stall_decode, 0);

        // One load-use stall after reset
        drv(1, 17, 1, 1, 0, 1, 0, 0, 0);
        drv(1, 18, 1, 0, 17, 1, 0, 0, 0);
        check("perf_lu_stall", stall_decode, 1);
`ifdef HAZARD_PERF_EN
        check("perf_stall_cnt0", stall_count, 0);
        check("perf_flush_cnt0", flush_count, 0);
`endif
        drv(1, 18, 1, 0, 17, 1, 0, 0, 0);
        check("perf_lu_fwd1", fwd_sel_rs1, 2);
`ifdef HAZARD_PERF_EN
        check("perf_stall_cnt1", stall_count, 1);
`endif
        nop();
        nop();
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Parametrised hazard-control block for the in-order RISC-V pipeline (fetch, decode, exec, memacc, writeback).
- Keeps a shift-register scoreboard of in-flight destination registers behind decode.
- Produces per-operand forwarding selects for the instruction in decode, a load-use stall, and flushes on taken branch/jump from exec.
- Generalises the fixed 5-stage wiring to DEPTH post-decode stages and a configurable load-data-ready stage.

Parameters:
- DEPTH, 3, number of post-decode stages tracked (index 0 = exec, DEPTH-1 = writeback)
- REG_AW, 5, register address width
- LOAD_READY, 1, first stage index whose output carries load data (1 = memacc)
- CNT_W, 32, width of performance counters (HAZARD_PERF_EN only)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- dec_valid  in  1  decode holds a real instruction
- dec_rs1_addr  in  REG_AW  rs1 of the decode instruction
- dec_rs2_addr  in  REG_AW  rs2 of the decode instruction
- dec_rs1_used  in  1  rs1 is read
- dec_rs2_used  in  1  rs2 is read
- dec_rd_addr  in  REG_AW  rd of the decode instruction
- dec_rd_write_enable  in  1  decode instruction writes rd
- dec_is_load  in  1  decode instruction is a load (res_src = memory)
- exec_pc_src  in  1  exec redirects fetch (taken branch or jump)
- stall_fetch  out  1  hold PC and the fetch→decode register
- stall_decode  out  1  hold the decode register; inject bubble into exec
- flush_decode  out  1  squash the fetch→decode register next edge
- flush_exec  out  1  squash the decode→exec register next edge
- fwd_sel_rs1  out  $clog2(DEPTH+1)  0 = regfile; k = output of stage k-1
- fwd_sel_rs2  out  $clog2(DEPTH+1)  as above for rs2
- stall_count  out  CNT_W  (HAZARD_PERF_EN only)
- flush_count  out  CNT_W  (HAZARD_PERF_EN only)

Behaviour:
- Scoreboard: sb[0..DEPTH-1] of {valid, rd, is_load}. Reset (async, rst_n low): all valid=0; all outputs 0.
- Match rule: entry j matches operand r when sb[j].valid, sb[j].rd == r, r != 0, and the operand is used. Register x0 never matches.
- Youngest wins: the lowest matching j selects fwd_sel = j+1. No match gives fwd_sel = 0.
- Load-use: a matching entry j with is_load=1 and j < LOAD_READY raises stall.
  - stall = dec_valid & load-use on either operand.
  - stall_fetch = stall_decode = stall.
  - fwd_sel is still driven but is don't-care while stall=1.
- Flush: exec_pc_src=1 gives flush_decode = flush_exec = 1 in the same cycle; all are combinational outputs. Flush overrides stall: both stall outputs are forced to 0 when exec_pc_src=1.
- Shift at each posedge:
  - sb[j] ← sb[j-1] for j ≥ 1.
  - sb[0] ← {dec_valid & dec_rd_write_enable & dec_rd_addr != 0, dec_rd_addr, dec_is_load}.
  - sb[0] ← bubble (valid=0) when stall=1 or exec_pc_src=1.
  - The entry leaving sb[DEPTH-1] is dropped.
- Writeback same cycle: a match in sb[DEPTH-1] forwards (fwd_sel = DEPTH), so the regfile needs no write-through.
- Combinational latency from inputs to outputs is 0 cycles. Scoreboard state updates 1 cycle later.
- Reset mid-operation clears all in-flight entries. The first post-reset decode reads the regfile only.
- Elaboration check: LOAD_READY < DEPTH and DEPTH ≥ 2, otherwise $error.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- When defined:
  - stall_count and flush_count ports exist.
  - Each increments by 1 per cycle with stall_decode=1 or flush_exec=1 respectively.
  - Both wrap modulo 2^CNT_W and reset to 0.
- When undefined: the ports and counters are absent. All other behaviour is identical.

Decomposition:
- Shared package hazard_pkg:
  - sb_entry_t struct {valid, rd[REG_AW-1:0], is_load}
  - REG_X0 constant
  - fwd_sel width helper function
- One sub-module, hazard_match: a combinational youngest-match priority search over the scoreboard for one operand, instantiated twice (rs1, rs2).

Test Plan:
- ADD x5 then next-cycle ADD x6,x5,x5 → fwd_sel_rs1 = fwd_sel_rs2 = 1, no stall.
- LW x7 then next-cycle ADD x8,x7,x1 → stall_decode=1 for exactly 1 cycle. Following cycle fwd_sel_rs1=2 and stall=0.
- ADDI x0,x0,1 then a consumer reading x0 → fwd_sel=0, no stall.
- ADD x9 at writeback with decode reading x9 (DEPTH=3) → fwd_sel=3. Two producers of x9 in sb[0] and sb[2] → fwd_sel=1.
- exec_pc_src=1 while a load-use stall is pending → flush_decode = flush_exec = 1, stall outputs 0, sb[0] bubble next cycle.
- rst_n low mid-stream with 3 valid entries → outputs 0 immediately. After release, a consumer of those rds gets fwd_sel=0. With HAZARD_PERF_EN, stall_count reads 0, then 1 after one load-use stall.
